// File: rtl/axi_read_arbiter_if.sv
// AXI4-Lite read channel bundle (AR + R) between the read arbiter and the shared RAM port.
interface axi_read_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4-Lite read channel between NUM_REQ requesters, one read in flight at a time.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins arbitration; default build is round-robin.
module axi_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic [1:0]                resp_resp,
  output logic                      busy,
  axi_read_arbiter_if.master        m_axil
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  grant_reg;
  logic [ADDR_W-1:0] araddr_reg;
  logic [DATA_W-1:0] resp_data_reg;
  logic [1:0]        resp_resp_reg;
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic              any_req;
  logic              accept;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  assign any_req = |req_valid;
  assign accept  = (state_reg == IDLE) && any_req;

`ifdef ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] scan_idx;

  // Descending scan so the lowest set index is the last assignment to stick.
  always_comb begin
    winner   = '0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = IDX_W'(k);
      if (req_valid[scan_idx]) winner = scan_idx;
    end
  end
`else
  logic [IDX_W-1:0] last_grant_reg;
  logic [IDX_W-1:0] scan_idx;
  logic             found;

  // Search starts just after the previous winner and wraps modulo NUM_REQ.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IDX_W'((int'(last_grant_reg) + k) % NUM_REQ);
      if (!found && req_valid[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
    end else if (accept) begin
      last_grant_reg <= winner;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = ADDR;
      ADDR:    if (m_axil.arready) state_next = DATA;
      DATA:    if (m_axil.rvalid) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = '0;
    resp_valid     = '0;
    m_axil.arvalid = 1'b0;
    m_axil.rready  = 1'b0;
    busy           = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (any_req) req_ready = NUM_REQ'(1) << winner;
      end
      ADDR:    m_axil.arvalid = 1'b1;
      DATA:    m_axil.rready  = 1'b1;
      RESP:    resp_valid     = NUM_REQ'(1) << grant_reg;
      default: busy = 1'b1;
    endcase
  end

  // Address and grant are captured at accept so requesters may drop or change them afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      araddr_reg    <= '0;
      grant_reg     <= '0;
      resp_data_reg <= '0;
      resp_resp_reg <= '0;
    end else begin
      if (accept) begin
        araddr_reg <= addr_arr[winner];
        grant_reg  <= winner;
      end
      if ((state_reg == DATA) && m_axil.rvalid) begin
        resp_data_reg <= m_axil.rdata;
        resp_resp_reg <= m_axil.rresp;
      end
    end
  end

  assign m_axil.araddr = araddr_reg;
  assign m_axil.arprot = 3'b000;
  assign resp_data     = resp_data_reg;
  assign resp_resp     = resp_resp_reg;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized self-checking bench for axi_read_arbiter with a behavioural AXI-Lite slave and arbitration model.
module tb_axi_read_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic [1:0]                resp_resp;
  logic                      busy;

  axi_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_axil ();

  axi_read_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_resp  (resp_resp),
    .busy       (busy),
    .m_axil     (m_axil)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model / slave control
  int                model_last = NUM_REQ - 1;
  logic [DATA_W-1:0] prev_data  = '0;
  int                ar_wait    = 0;
  int                r_wait     = 0;
  int                resp_mode  = -1;
  bit                data_force = 1'b0;
  logic [DATA_W-1:0] force_data = '0;
  logic [ADDR_W-1:0] ar_addr_q [$];
  logic [DATA_W-1:0] rdata_q   [$];
  logic [1:0]        rresp_q   [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int last, input logic [NUM_REQ-1:0] v);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NUM_REQ; k++) if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
`endif
    return -1;
  endfunction

  // AXI-Lite slave: arready after ar_wait cycles of arvalid, rvalid r_wait cycles after AR handshake.
  initial begin
    m_axil.arready = 1'b0;
    m_axil.rvalid  = 1'b0;
    m_axil.rdata   = '0;
    m_axil.rresp   = '0;
    forever begin
      @(negedge clk);
      if (m_axil.arvalid && rst) begin
        repeat (ar_wait) @(negedge clk);
        ar_addr_q.push_back(m_axil.araddr);
        m_axil.arready = 1'b1;
        @(negedge clk);
        m_axil.arready = 1'b0;
        repeat (r_wait) @(negedge clk);
        m_axil.rdata  = data_force ? force_data : DATA_W'($urandom);
        m_axil.rresp  = (resp_mode < 0) ? 2'($urandom_range(0, 3)) : 2'(resp_mode);
        m_axil.rvalid = 1'b1;
        for (int k = 0; k < 8 && !m_axil.rready; k++) @(negedge clk);
        if (m_axil.rready) begin
          rdata_q.push_back(m_axil.rdata);
          rresp_q.push_back(m_axil.rresp);
        end
        @(negedge clk);
        m_axil.rvalid = 1'b0;
      end
    end
  end

  task automatic check_scoreboard(input logic [ADDR_W-1:0] exp_addr);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [1:0]        r;
    if (ar_addr_q.size() == 0 || rdata_q.size() == 0 || rresp_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      a = ar_addr_q.pop_front();
      d = rdata_q.pop_front();
      r = rresp_q.pop_front();
      check_eq("slave_araddr", a, exp_addr);
      check_eq("resp_data", resp_data, d);
      check_eq("resp_resp", resp_resp, r);
      prev_data = d;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_arvalid", m_axil.arvalid, 0);
    check_eq("rst_rready", m_axil.rready, 0);
    check_eq("rst_araddr", m_axil.araddr, 0);
    check_eq("rst_arprot", m_axil.arprot, 0);
    check_eq("rst_resp_data", resp_data, 0);
    check_eq("rst_resp_resp", resp_resp, 0);
    rst = 1'b1;
    model_last = NUM_REQ - 1;
    prev_data  = '0;
    ar_addr_q.delete();
    rdata_q.delete();
    rresp_q.delete();
  endtask

  // One read from IDLE; noisy keeps random requests active while busy.
  task automatic do_read(input logic [NUM_REQ-1:0] pat, input int arw, input int rw,
                         input bit noisy, input bit rand_addr, output logic [NUM_REQ-1:0] got_rv);
    int exp;
    int lat;
    bit seen;
    logic [ADDR_W-1:0] exp_addr;
    ar_wait = arw;
    r_wait  = rw;
    got_rv  = '0;
    req_valid = pat;
    if (rand_addr)
      for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
    #1;
    exp      = pick(model_last, pat);
    exp_addr = req_addr[exp*ADDR_W +: ADDR_W];
    check_eq("req_ready", req_ready, 1 << exp);
    check_eq("idle_busy", busy, 0);
    @(negedge clk);
    model_last = exp;
    req_valid  = noisy ? NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)) : '0;
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
    seen = 1'b0;
    lat  = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      #1;
      if (resp_valid != 0) begin
        seen   = 1'b1;
        lat    = cyc;
        got_rv = resp_valid;
        req_valid = '0;
        break;
      end
      check_eq("busy", busy, 1);
      check_eq("busy_req_ready", req_ready, 0);
      check_eq("araddr_stable", m_axil.araddr, exp_addr);
      check_eq("resp_hold", resp_data, prev_data);
      if (cyc <= arw + 1) begin
        check_eq("arvalid", m_axil.arvalid, 1);
        check_eq("addr_rready", m_axil.rready, 0);
      end
      @(negedge clk);
    end
    if (!seen) begin
      check_eq("resp_timeout", 64'd0, 64'd1);
    end else begin
      check_eq("resp_valid", resp_valid, 1 << exp);
      check_eq("latency", lat, 3 + arw + rw);
      check_scoreboard(exp_addr);
      $display("read req=%0d addr=%h data=%h resp=%0d lat=%0d", exp, exp_addr, resp_data, resp_resp, lat);
    end
    @(negedge clk);
    #1;
    check_eq("resp_pulse_end", resp_valid, 0);
    check_eq("back_idle", busy, 0);
  endtask

  // Requests held for n back-to-back reads with a zero-wait slave.
  task automatic burst(input logic [NUM_REQ-1:0] pat, input int n);
    int exp;
    int lat;
    bit seen;
    logic [ADDR_W-1:0] exp_addr;
    ar_wait = 0;
    r_wait  = 0;
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
    req_valid = pat;
    for (int j = 0; j < n; j++) begin
      exp      = pick(model_last, pat);
      exp_addr = req_addr[exp*ADDR_W +: ADDR_W];
      seen = 1'b0;
      lat  = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
        @(negedge clk);
        #1;
        if (resp_valid != 0) begin
          seen = 1'b1;
          lat  = cyc;
          break;
        end
      end
      if (!seen) begin
        check_eq("burst_timeout", 64'd0, 64'd1);
      end else begin
        check_eq("grant_order", resp_valid, 1 << exp);
        check_eq("issue_interval", lat, (j == 0) ? 3 : 4);
        check_scoreboard(exp_addr);
        $display("burst req=%0d addr=%h data=%h resp=%0d gap=%0d", exp, exp_addr, resp_data, resp_resp, lat);
      end
      model_last = exp;
      if (j == n - 1) req_valid = '0;
    end
    @(negedge clk);
    #1;
    check_eq("burst_idle", busy, 0);
  endtask

  task automatic reset_mid_data();
    bit seen;
    logic [NUM_REQ-1:0] v;
    ar_wait = 0;
    r_wait  = 4;
    req_valid = 4'b0010;
    req_addr[1*ADDR_W +: ADDR_W] = 16'hA5A5;
    @(negedge clk);
    req_valid = '0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (m_axil.rready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("reach_data", seen, 1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_rready", m_axil.rready, 0);
    check_eq("mid_rst_arvalid", m_axil.arvalid, 0);
    check_eq("mid_rst_araddr", m_axil.araddr, 0);
    check_eq("mid_rst_resp_data", resp_data, 0);
    check_eq("mid_rst_resp_valid", resp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    v = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      #1;
      v = v | resp_valid;
      check_eq("stale_busy", busy, 0);
      check_eq("stale_rready", m_axil.rready, 0);
    end
    check_eq("stale_no_resp", v, 0);
    $display("reset mid-read: stale rvalid ignored");
    ar_addr_q.delete();
    rdata_q.delete();
    rresp_q.delete();
    model_last = NUM_REQ - 1;
    prev_data  = '0;
  endtask

  initial begin
    logic [NUM_REQ-1:0] rv;
    apply_reset();

    // basic read with known address and data
    req_addr   = '0;
    req_addr[15:0] = 16'h0010;
    data_force = 1'b1;
    force_data = 32'hDEADBEEF;
    resp_mode  = 0;
    do_read(4'b0001, 1, 0, 1'b0, 1'b0, rv);
    check_eq("t1_grant", rv, 4'b0001);
    check_eq("t1_data", resp_data, 32'hDEADBEEF);
    check_eq("t1_resp", resp_resp, 2'b00);
    data_force = 1'b0;
    resp_mode  = -1;

    // held requests: fair rotation and sole-requester re-grant
    burst(4'b1111, 4);
    burst(4'b0100, 2);

    // slow arready with other requests pending
    do_read(4'b1010, 5, 0, 1'b1, 1'b1, rv);

    // error response routed to its requester only
    resp_mode = 2;
    do_read(4'b0110, 0, 2, 1'b0, 1'b1, rv);
    check_eq("t4_resp", resp_resp, 2'b10);
    resp_mode = -1;

    // wrap past the top index
    apply_reset();
    do_read(4'b0001, 0, 0, 1'b0, 1'b1, rv);
    do_read(4'b0010, 0, 0, 1'b0, 1'b1, rv);
    do_read(4'b0100, 0, 0, 1'b0, 1'b1, rv);
    do_read(4'b0101, 0, 0, 1'b0, 1'b1, rv);
    check_eq("wrap_grant", rv, 4'b0001);

    reset_mid_data();
    do_read(4'b1111, 0, 0, 1'b0, 1'b1, rv);
    check_eq("post_rst_first", rv, 4'b0001);

    for (int n = 0; n < 40; n++) begin
      do_read(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)),
              $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'b1, rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
